decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered, flow-controlled RV32I decode stage between fetch and execute.
- Decodes every RV32I base opcode into register indices, a sign-extended immediate, an ALU/branch operation and a write-enable.
- Buffers decoded results in a DEPTH-entry queue using a valid/ready handshake on both sides.
- Flags illegal encodings and supports a pipeline flush.

Parameters:
- XLEN, 32, width of PC and immediate outputs. The immediate is sign-extended to XLEN; only 32 is required in synthesis.
- DEPTH, 2, number of decoded-instruction queue entries. Legal values are 1..8.
- ZERO_RD_NO_WE, 1, when 1, r_we is forced to 0 whenever rd == 0.

Ports:
- clk in 1 system clock
- rst_n in 1 asynchronous active-low reset
- flush in 1 discard all queued and incoming instructions
- in_valid in 1 fetch presents instruction
- in_ready out 1 stage can accept
- in_instr in 32 instruction word, interpreted as rv32i_inst_u
- in_pc in XLEN PC of in_instr
- out_valid out 1 decoded entry at queue head
- out_ready in 1 execute consumes head
- out_pc out XLEN PC of head
- out_rs1 out 5 source register 1
- out_rs2 out 5 source register 2
- out_rd out 5 destination register
- out_imm out XLEN sign-extended immediate
- out_rv_op out rv_op_e decoded operation
- out_r_we out 1 register write enable
- out_illegal out 1 head is an illegal instruction

Behaviour:
- Reset (async assert, sync-release use): count = 0, wr_ptr = 0, rd_ptr = 0.
  - in_ready = 1; out_valid = 0.
  - All out_* data = 0, out_rv_op = first enumerator.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- in_ready = (count != DEPTH). No full-bypass: when full, a same-cycle pop does not raise in_ready that cycle.
- Latency is 1 cycle: an instruction accepted at edge N appears at out_* with out_valid = 1 after edge N.
- out_* is driven from the queue head register. It is stable while out_valid && !out_ready.
- Simultaneous push and pop leaves count unchanged; both pointers advance.
- Pointers wrap modulo DEPTH.
- Flush (sync): at the next edge, count = 0 and pointers = 0. Any push in the flush cycle is dropped. out_valid = 0 the following cycle.
  - Flush has priority over push and pop.
- Decode is combinational, before the queue write.
- Type selection is by opcode:
  - R: OP
  - I: OP-IMM, LOAD, JALR, SYSTEM, MISC-MEM
  - S: STORE
  - B: BRANCH
  - U: LUI, AUIPC
  - J: JAL
- Immediates per type (all sign-extended from the top bit):
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R: 0.
- Register fields not used by the type are driven to 0.
  - rs1 is 0 for U and J.
  - rs2 is 0 for I, U and J.
  - rd is 0 for S and B.
- AUIPC decodes to RV_AUIPC, distinct from RV_LUI.
- rv_op mapping:
  - R-type and OP-IMM ops use funct3/funct7.
  - Funct7 0x20 is legal only for SUB, SRA and SRAI.
  - SLLI, SRLI and SRAI require the correct funct7.
- r_we = 1 for R, I, U and J types.
- r_we = 0 for S, B, MISC-MEM, ECALL/EBREAK and illegal instructions.
- r_we = 0 when rd == 0 and ZERO_RD_NO_WE = 1.
- out_illegal = 1 when any of the following holds:
  - the opcode is unknown;
  - instr[1:0] != 2'b11;
  - the funct3/funct7 combination is invalid;
  - the branch funct3 is 010 or 011;
  - the load/store funct3 is invalid.
- An illegal entry still flows through the queue with r_we = 0 and rv_op = RV_ILLEGAL.

Decomposition:
- Shared package define.sv holds rv32i_inst_u, opcode_e, optype_e and rv_op_e.
  - rv_op_e is extended with RV_AUIPC, RV_JAL, RV_JALR, RV_LOAD*, RV_STORE*, RV_FENCE, RV_ECALL, RV_EBREAK and RV_ILLEGAL.
  - A new decoded_t struct (rs1, rs2, rd, imm, rv_op, r_we, illegal) is added.
- One combinational sub-module, rv32i_decode_core, maps instr to decoded_t.
- decode_stage owns the queue, pointers and handshake.

Test Plan:
- LUI 0x123452B7, out_ready = 1:
  - One cycle later, out_valid = 1, rd = 5, imm = 0x12345000, rv_op = RV_LUI, r_we = 1, illegal = 0.
- ADDI 0xFFF00093, then BEQ 0xFE208EE3, back-to-back:
  - ADDI: rd = 1, rs1 = 0, imm = 0xFFFFFFFF, r_we = 1.
  - BEQ: rs1 = 1, rs2 = 2, rd = 0, imm = 0xFFFFFFFC, r_we = 0.
- SW 0x0020A423:
  - rs1 = 1, rs2 = 2, imm = 0x00000008, rd = 0, r_we = 0.
- Backpressure: out_ready = 0, push 3 instructions with DEPTH = 2:
  - in_ready drops after the 2nd accept; the 3rd is held.
  - Raising out_ready drains all 3 in order with PCs preserved.
- Illegal cases:
  - 0x00000000 gives illegal = 1, r_we = 0, rv_op = RV_ILLEGAL.
  - 0x40001033 (funct7 0x20 with SLL) gives illegal = 1.
  - ADD with rd = 0 (0x00208033) gives r_we = 0.
- Flush with 2 queued entries and a concurrent push:
  - Next cycle out_valid = 0, in_ready = 1, and the pushed instruction never appears.
  - rst_n asserted mid-stream clears out_valid asynchronously.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// -----------------------------------------------------------------------------
// decode_stage_pkg
//   Shared RV32I definitions for the decode stage: instruction word view,
//   opcode / format / operation enumerations, the decoded-instruction record
//   and small helpers for ALU-op selection and immediate extraction.
//   No ports (package).
// -----------------------------------------------------------------------------
package decode_stage_pkg;

  typedef enum logic [6:0] {
    OPC_LOAD     = 7'b0000011,
    OPC_MISC_MEM = 7'b0001111,
    OPC_OP_IMM   = 7'b0010011,
    OPC_AUIPC    = 7'b0010111,
    OPC_STORE    = 7'b0100011,
    OPC_OP       = 7'b0110011,
    OPC_LUI      = 7'b0110111,
    OPC_BRANCH   = 7'b1100011,
    OPC_JALR     = 7'b1100111,
    OPC_JAL      = 7'b1101111,
    OPC_SYSTEM   = 7'b1110011
  } opcode_e;

  typedef enum logic [2:0] {
    OPT_R,
    OPT_I,
    OPT_S,
    OPT_B,
    OPT_U,
    OPT_J
  } optype_e;

  // RV_ADD is the first enumerator and therefore the reset value of the head.
  typedef enum logic [5:0] {
    RV_ADD, RV_SUB, RV_SLL, RV_SLT, RV_SLTU, RV_XOR, RV_SRL, RV_SRA,
    RV_OR, RV_AND, RV_LUI, RV_AUIPC, RV_JAL, RV_JALR,
    RV_BEQ, RV_BNE, RV_BLT, RV_BGE, RV_BLTU, RV_BGEU,
    RV_LOADB, RV_LOADH, RV_LOADW, RV_LOADBU, RV_LOADHU,
    RV_STOREB, RV_STOREH, RV_STOREW,
    RV_FENCE, RV_ECALL, RV_EBREAK, RV_ILLEGAL
  } rv_op_e;

  // R-type field layout; the other formats are sliced from raw directly.
  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } rv32i_r_t;

  typedef union packed {
    logic [31:0] raw;
    rv32i_r_t    r;
  } rv32i_inst_u;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    rv_op_e      rv_op;
    logic        r_we;
    logic        illegal;
  } decoded_t;

  // funct3 -> ALU op; alt selects the funct7=0x20 variant (SUB / SRA).
  function automatic rv_op_e alu_op(input logic [2:0] f3, input logic alt);
    rv_op_e op;
    case (f3)
      3'b000:  op = alt ? RV_SUB : RV_ADD;
      3'b001:  op = RV_SLL;
      3'b010:  op = RV_SLT;
      3'b011:  op = RV_SLTU;
      3'b100:  op = RV_XOR;
      3'b101:  op = alt ? RV_SRA : RV_SRL;
      3'b110:  op = RV_OR;
      default: op = RV_AND;
    endcase
    return op;
  endfunction

  // Immediate assembly; the opcode bits [6:0] never contribute.
  function automatic logic [31:0] imm_of(input optype_e t, input logic [31:7] i);
    logic [31:0] imm;
    case (t)
      OPT_I:   imm = {{20{i[31]}}, i[31:20]};
      OPT_S:   imm = {{20{i[31]}}, i[31:25], i[11:7]};
      OPT_B:   imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      OPT_U:   imm = {i[31:12], 12'b0};
      OPT_J:   imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: imm = 32'b0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_stage_rv32i_decode_core.sv
// -----------------------------------------------------------------------------
// rv32i_decode_core
//   Purely combinational RV32I decoder: instruction word -> decoded_t.
//   Ports:
//     instr_i  in  rv32i_inst_u  instruction word
//     dec_o    out decoded_t     register indices, immediate, op, r_we, illegal
//   Illegal encodings produce an all-zero record with rv_op = RV_ILLEGAL and
//   illegal = 1, so nothing downstream can act on stray field values.
// -----------------------------------------------------------------------------
module rv32i_decode_core
  import decode_stage_pkg::*;
#(
  parameter int unsigned ZERO_RD_NO_WE = 1
) (
  input  rv32i_inst_u instr_i,
  output decoded_t    dec_o
);

  opcode_e    opc;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opc = opcode_e'(instr_i.r.opcode);
  assign f3  = instr_i.r.funct3;
  assign f7  = instr_i.r.funct7;

  optype_e ty;
  rv_op_e  op;
  logic    legal;
  logic    no_wb;   // I-format instructions that never write rd

  always_comb begin
    ty    = OPT_R;
    op    = RV_ILLEGAL;
    legal = 1'b0;
    no_wb = 1'b0;
    case (opc)
      OPC_OP: begin
        ty = OPT_R;
        if (f7 == 7'h00) begin
          op    = alu_op(f3, 1'b0);
          legal = 1'b1;
        end else if (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)) begin
          op    = alu_op(f3, 1'b1);
          legal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        ty = OPT_I;
        // Shift-immediates carry funct7 in imm[11:5]; other ops take any imm.
        if (f3 == 3'b001) begin
          op    = RV_SLL;
          legal = (f7 == 7'h00);
        end else if (f3 == 3'b101) begin
          op    = (f7 == 7'h20) ? RV_SRA : RV_SRL;
          legal = (f7 == 7'h00) || (f7 == 7'h20);
        end else begin
          op    = alu_op(f3, 1'b0);
          legal = 1'b1;
        end
      end
      OPC_LOAD: begin
        ty    = OPT_I;
        legal = 1'b1;
        case (f3)
          3'b000:  op = RV_LOADB;
          3'b001:  op = RV_LOADH;
          3'b010:  op = RV_LOADW;
          3'b100:  op = RV_LOADBU;
          3'b101:  op = RV_LOADHU;
          default: legal = 1'b0;
        endcase
      end
      OPC_STORE: begin
        ty    = OPT_S;
        legal = 1'b1;
        case (f3)
          3'b000:  op = RV_STOREB;
          3'b001:  op = RV_STOREH;
          3'b010:  op = RV_STOREW;
          default: legal = 1'b0;
        endcase
      end
      OPC_BRANCH: begin
        ty    = OPT_B;
        legal = 1'b1;
        case (f3)
          3'b000:  op = RV_BEQ;
          3'b001:  op = RV_BNE;
          3'b100:  op = RV_BLT;
          3'b101:  op = RV_BGE;
          3'b110:  op = RV_BLTU;
          3'b111:  op = RV_BGEU;
          default: legal = 1'b0;
        endcase
      end
      OPC_JALR: begin
        ty    = OPT_I;
        op    = RV_JALR;
        legal = (f3 == 3'b000);
      end
      OPC_JAL: begin
        ty    = OPT_J;
        op    = RV_JAL;
        legal = 1'b1;
      end
      OPC_LUI: begin
        ty    = OPT_U;
        op    = RV_LUI;
        legal = 1'b1;
      end
      OPC_AUIPC: begin
        ty    = OPT_U;
        op    = RV_AUIPC;
        legal = 1'b1;
      end
      OPC_MISC_MEM: begin
        ty    = OPT_I;
        op    = RV_FENCE;
        no_wb = 1'b1;
        legal = (f3 == 3'b000);
      end
      OPC_SYSTEM: begin
        ty    = OPT_I;
        no_wb = 1'b1;
        // Only the two exact base encodings; CSR forms are not part of RV32I.
        if (instr_i.raw[31:7] == 25'h0000000) begin
          op    = RV_ECALL;
          legal = 1'b1;
        end else if (instr_i.raw[31:7] == 25'h0002000) begin
          op    = RV_EBREAK;
          legal = 1'b1;
        end
      end
      default: ;
    endcase
    if (instr_i.raw[1:0] != 2'b11) legal = 1'b0;
  end

  always_comb begin
    dec_o         = '0;
    dec_o.rv_op   = RV_ILLEGAL;
    dec_o.illegal = 1'b1;
    if (legal) begin
      dec_o.illegal = 1'b0;
      dec_o.rv_op   = op;
      dec_o.imm     = imm_of(ty, instr_i.raw[31:7]);
      dec_o.rs1     = (ty == OPT_U || ty == OPT_J) ? 5'd0 : instr_i.r.rs1;
      dec_o.rs2     = (ty == OPT_R || ty == OPT_S || ty == OPT_B) ? instr_i.r.rs2 : 5'd0;
      dec_o.rd      = (ty == OPT_S || ty == OPT_B) ? 5'd0 : instr_i.r.rd;
      dec_o.r_we    = !no_wb && !(ty == OPT_S || ty == OPT_B) &&
                      !((ZERO_RD_NO_WE != 0) && instr_i.r.rd == 5'd0);
    end
  end

endmodule

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//   Registered RV32I decode stage: decodes the incoming word combinationally
//   and stores the result in a DEPTH-entry circular queue read at the head.
//   Ports:
//     clk, rst_n         clock, asynchronous active-low reset
//     flush              drop every queued entry and any same-cycle push
//     in_valid/in_ready  fetch handshake; in_instr, in_pc carried with it
//     out_valid/out_ready execute handshake on the queue head
//     out_pc, out_rs1, out_rs2, out_rd, out_imm, out_rv_op, out_r_we,
//     out_illegal        decoded fields of the head entry
//
//   Handshake: a transfer happens on a rising edge where valid && ready on
//   that side. in_ready depends only on the occupancy (no same-cycle bypass
//   when full), out_* is held stable while out_valid && !out_ready, and
//   flush overrides both push and pop for that edge.
// -----------------------------------------------------------------------------
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int DEPTH         = 2,
  parameter int ZERO_RD_NO_WE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output rv_op_e          out_rv_op,
  output logic            out_r_we,
  output logic            out_illegal
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  rv32i_inst_u inst;
  decoded_t    dec;

  assign inst = in_instr;

  rv32i_decode_core #(
    .ZERO_RD_NO_WE(ZERO_RD_NO_WE)
  ) u_core (
    .instr_i(inst),
    .dec_o  (dec)
  );

  decoded_t         ent_q [DEPTH];
  logic [XLEN-1:0]  pc_q  [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;

  assign in_ready  = (count_q != CNT_FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (!push && pop) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is cleared on reset so the head reads as all-zero / RV_ADD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
        pc_q[i]  <= '0;
      end
    end else if (push && !flush) begin
      ent_q[wr_ptr_q] <= dec;
      pc_q[wr_ptr_q]  <= in_pc;
    end
  end

  decoded_t head;
  assign head = ent_q[rd_ptr_q];

  assign out_pc      = pc_q[rd_ptr_q];
  assign out_rs1     = head.rs1;
  assign out_rs2     = head.rs2;
  assign out_rd      = head.rd;
  assign out_imm     = XLEN'($signed(head.imm));
  assign out_rv_op   = head.rv_op;
  assign out_r_we    = head.r_we;
  assign out_illegal = head.illegal;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
  import decode_stage_pkg::*;

  localparam int EXP_W = 87;
  localparam int NVEC  = 22;

  // ---------------- clock / reset / DUT ----------------
  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [31:0] out_imm;
  rv_op_e      out_rv_op;
  logic        out_r_we;
  logic        out_illegal;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  decode_stage #(.XLEN(32), .DEPTH(2), .ZERO_RD_NO_WE(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_rs1    (out_rs1),
    .out_rs2    (out_rs2),
    .out_rd     (out_rd),
    .out_imm    (out_imm),
    .out_rv_op  (out_rv_op),
    .out_r_we   (out_r_we),
    .out_illegal(out_illegal)
  );

  // ---------------- vectors / scoreboard ----------------
  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    rv_op_e      op;
    logic        we;
    logic        ill;
  } vec_t;

  vec_t             vecs [NVEC];
  logic [EXP_W-1:0] exp_q [$];
  logic [EXP_W-1:0] cur_exp;
  int               n_checks;
  int               n_fail;
  logic             rand_mode;

  function automatic vec_t mk(input logic [31:0] instr, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [31:0] imm, input rv_op_e op,
                              input logic we, input logic ill);
    vec_t v;
    v.instr = instr; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.imm = imm; v.op = op; v.we = we; v.ill = ill;
    return v;
  endfunction

  function automatic logic [EXP_W-1:0] exp_of(input vec_t v, input logic [31:0] pc);
    return {pc, v.rs1, v.rs2, v.rd, v.imm, v.op, v.we, v.ill};
  endfunction

  function automatic logic [EXP_W-1:0] pack_out();
    return {out_pc, out_rs1, out_rs2, out_rd, out_imm, out_rv_op, out_r_we, out_illegal};
  endfunction

  task automatic chk(input string name, input logic [EXP_W-1:0] act,
                     input logic [EXP_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: observe handshakes at the falling edge, then return 1 time unit
  // after the next rising edge, where inputs are changed.
  task automatic tick();
    @(negedge clk);
    if (!rst_n || flush) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got %h expected nothing", pack_out());
        end else begin
          chk("head", pack_out(), exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(cur_exp);
    end
    @(posedge clk);
    #1;
    if (rand_mode) out_ready = 1'($urandom_range(0, 1));
  endtask

  // ---------------- driver tasks ----------------
  task automatic push(input vec_t v, input logic [31:0] pc);
    int   n;
    logic acc;
    in_valid = 1'b1;
    in_instr = v.instr;
    in_pc    = pc;
    cur_exp  = exp_of(v, pc);
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 100) begin
      acc = in_ready;
      tick();
      n++;
    end
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout: got in_ready=0 for %0d cycles expected accept", n);
      in_valid = 1'b0;
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    chk("drain_left", EXP_W'(exp_q.size()), '0);
  endtask

  // ---------------- test ----------------
  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rand_mode = 1'b0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    out_ready = 1'b0;
    cur_exp   = '0;

    vecs[0]  = mk(32'h123452B7, 5'd0, 5'd0, 5'd5,  32'h12345000, RV_LUI,     1'b1, 1'b0);
    vecs[1]  = mk(32'hFFF00093, 5'd0, 5'd0, 5'd1,  32'hFFFFFFFF, RV_ADD,     1'b1, 1'b0);
    vecs[2]  = mk(32'hFE208EE3, 5'd1, 5'd2, 5'd0,  32'hFFFFFFFC, RV_BEQ,     1'b0, 1'b0);
    vecs[3]  = mk(32'h0020A423, 5'd1, 5'd2, 5'd0,  32'h00000008, RV_STOREW,  1'b0, 1'b0);
    vecs[4]  = mk(32'h00000000, 5'd0, 5'd0, 5'd0,  32'h0,        RV_ILLEGAL, 1'b0, 1'b1);
    vecs[5]  = mk(32'h40001033, 5'd0, 5'd0, 5'd0,  32'h0,        RV_ILLEGAL, 1'b0, 1'b1);
    vecs[6]  = mk(32'h00208033, 5'd1, 5'd2, 5'd0,  32'h0,        RV_ADD,     1'b0, 1'b0);
    vecs[7]  = mk(32'hFFFFF517, 5'd0, 5'd0, 5'd10, 32'hFFFFF000, RV_AUIPC,   1'b1, 1'b0);
    vecs[8]  = mk(32'h008000EF, 5'd0, 5'd0, 5'd1,  32'h00000008, RV_JAL,     1'b1, 1'b0);
    vecs[9]  = mk(32'hFFDFF06F, 5'd0, 5'd0, 5'd0,  32'hFFFFFFFC, RV_JAL,     1'b0, 1'b0);
    vecs[10] = mk(32'h40525193, 5'd4, 5'd0, 5'd3,  32'h00000405, RV_SRA,     1'b1, 1'b0);
    vecs[11] = mk(32'h40521193, 5'd0, 5'd0, 5'd0,  32'h0,        RV_ILLEGAL, 1'b0, 1'b1);
    vecs[12] = mk(32'h00002063, 5'd0, 5'd0, 5'd0,  32'h0,        RV_ILLEGAL, 1'b0, 1'b1);
    vecs[13] = mk(32'hFFF3A303, 5'd7, 5'd0, 5'd6,  32'hFFFFFFFF, RV_LOADW,   1'b1, 1'b0);
    vecs[14] = mk(32'h00003003, 5'd0, 5'd0, 5'd0,  32'h0,        RV_ILLEGAL, 1'b0, 1'b1);
    vecs[15] = mk(32'h00000073, 5'd0, 5'd0, 5'd0,  32'h0,        RV_ECALL,   1'b0, 1'b0);
    vecs[16] = mk(32'h00100073, 5'd0, 5'd0, 5'd0,  32'h00000001, RV_EBREAK,  1'b0, 1'b0);
    vecs[17] = mk(32'h0FF0000F, 5'd0, 5'd0, 5'd0,  32'h000000FF, RV_FENCE,   1'b0, 1'b0);
    vecs[18] = mk(32'h00000010, 5'd0, 5'd0, 5'd0,  32'h0,        RV_ILLEGAL, 1'b0, 1'b1);
    vecs[19] = mk(32'h407302B3, 5'd6, 5'd7, 5'd5,  32'h0,        RV_SUB,     1'b1, 1'b0);
    vecs[20] = mk(32'h000280E7, 5'd5, 5'd0, 5'd1,  32'h0,        RV_JALR,    1'b1, 1'b0);
    vecs[21] = mk(32'hFE310FA3, 5'd2, 5'd3, 5'd0,  32'hFFFFFFFF, RV_STOREB,  1'b0, 1'b0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready",  EXP_W'(in_ready),  EXP_W'(1));
    chk("reset_out_valid", EXP_W'(out_valid), EXP_W'(0));
    chk("reset_out_data",  pack_out(), '0);
    rst_n = 1'b1;
    tick();

    // Latency: LUI accepted at one edge is visible right after it
    out_ready = 1'b1;
    push(vecs[0], 32'h0000_1000);
    chk("latency_valid", EXP_W'(out_valid), EXP_W'(1));
    chk("latency_rd",    EXP_W'(out_rd),    EXP_W'(5));
    drain();

    // Table, back-to-back with the consumer always ready
    for (int i = 0; i < NVEC; i++) push(vecs[i], 32'h0000_2000 + 32'(i * 4));
    drain();

    // Table again with random gaps and random consumer stalls
    rand_mode = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) idle();
      push(vecs[i], 32'h0000_3000 + 32'(i * 4));
    end
    drain();
    rand_mode = 1'b0;

    // Backpressure: fill both entries, hold the third, then drain in order
    out_ready = 1'b0;
    push(vecs[1], 32'h0000_4000);
    push(vecs[2], 32'h0000_4004);
    chk("full_in_ready", EXP_W'(in_ready), EXP_W'(0));
    in_valid = 1'b1;
    in_instr = vecs[3].instr;
    in_pc    = 32'h0000_4008;
    cur_exp  = exp_of(vecs[3], 32'h0000_4008);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("hold_in_ready", EXP_W'(in_ready), EXP_W'(0));
      chk("hold_head_pc",  EXP_W'(out_pc),   EXP_W'(32'h0000_4000));
    end
    out_ready = 1'b1;
    chk("no_bypass_in_ready", EXP_W'(in_ready), EXP_W'(0));
    push(vecs[3], 32'h0000_4008);
    drain();

    // Flush with two queued entries and a concurrent push
    out_ready = 1'b0;
    push(vecs[7], 32'h0000_5000);
    push(vecs[8], 32'h0000_5004);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = vecs[10].instr;
    in_pc    = 32'h0000_5008;
    cur_exp  = exp_of(vecs[10], 32'h0000_5008);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", EXP_W'(out_valid), EXP_W'(0));
    chk("flush_in_ready",  EXP_W'(in_ready),  EXP_W'(1));
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      idle();
      chk("post_flush_empty", EXP_W'(out_valid), EXP_W'(0));
    end
    push(vecs[19], 32'h0000_500C);
    drain();

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    push(vecs[13], 32'h0000_6000);
    push(vecs[20], 32'h0000_6004);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_out_valid", EXP_W'(out_valid), EXP_W'(0));
    chk("areset_in_ready",  EXP_W'(in_ready),  EXP_W'(1));
    chk("areset_out_data",  pack_out(), '0);
    tick();
    rst_n = 1'b1;
    idle();
    out_ready = 1'b1;
    push(vecs[21], 32'h0000_6008);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
